// File: rtl/decode_control_unit.sv
// Decode-stage control for the 5-stage pipeline: instruction buffer, field split,
// control/PC-flag/ALU-op generation and register-number selection.

module MUX #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned INPUTS = 2,
    localparam int unsigned SelW  = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic [INPUTS*WIDTH-1:0] inputs,
    input  logic [SelW-1:0]         sel,
    output logic [WIDTH-1:0]        result
);

    // Input 0 occupies the least-significant slice; out-of-range selects give zero.
    always_comb begin
        result = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (sel == SelW'(i)) begin
                result = inputs[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

module decode_control_unit (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        turn_off,
    input  logic        add_rd,
    output logic [5:0]  op_code,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic [13:0] imm,
    output logic [7:0]  cu_flags,
    output logic        call,
    output logic        jump_f,
    output logic        jr_f,
    output logic        bz,
    output logic        gz,
    output logic        lz,
    output logic [1:0]  alu_op,
    output logic [3:0]  rb,
    output logic [3:0]  rd_buf
);

    localparam logic [5:0] OpOr   = 6'd0;
    localparam logic [5:0] OpAdd  = 6'd1;
    localparam logic [5:0] OpSub  = 6'd2;
    localparam logic [5:0] OpCmp  = 6'd3;
    localparam logic [5:0] OpOri  = 6'd4;
    localparam logic [5:0] OpAddi = 6'd5;
    localparam logic [5:0] OpLw   = 6'd6;
    localparam logic [5:0] OpLdw  = 6'd7;
    localparam logic [5:0] OpSw   = 6'd8;
    localparam logic [5:0] OpSdw  = 6'd9;
    localparam logic [5:0] OpBz   = 6'd10;
    localparam logic [5:0] OpBgz  = 6'd11;
    localparam logic [5:0] OpBlz  = 6'd12;
    localparam logic [5:0] OpJr   = 6'd13;
    localparam logic [5:0] OpJ    = 6'd14;
    localparam logic [5:0] OpCll  = 6'd15;

    localparam logic [1:0] AluOr  = 2'b00;
    localparam logic [1:0] AluAdd = 2'b01;
    localparam logic [1:0] AluSub = 2'b10;
    localparam logic [1:0] AluCmp = 2'b11;

    localparam logic [3:0] LinkReg = 4'hE;

    logic [31:0] buffer_q;
    logic        valid_q;
    logic        bubble;

    logic [7:0]  flags_raw;
    logic [1:0]  alu_raw;
    logic [5:0]  pc_raw;   // {call, jump_f, jr_f, bz, gz, lz}

    logic [3:0]  rd_plus1;
    logic [3:0]  rd_value;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            buffer_q <= '0;
            valid_q  <= 1'b0;
        end else if (!(stall || turn_off)) begin
            buffer_q <= instruction;
            valid_q  <= 1'b1;
        end
    end

    assign op_code = buffer_q[31:26];
    assign rd      = buffer_q[25:22];
    assign rs      = buffer_q[21:18];
    assign rt      = buffer_q[17:14];
    assign imm     = buffer_q[13:0];

    always_comb begin
        flags_raw = 8'h00;
        alu_raw   = AluOr;
        pc_raw    = 6'b000000;
        case (op_code)
            OpOr:   begin flags_raw = 8'h01; alu_raw = AluOr;  end
            OpAdd:  begin flags_raw = 8'h01; alu_raw = AluAdd; end
            OpSub:  begin flags_raw = 8'h01; alu_raw = AluSub; end
            OpCmp:  begin flags_raw = 8'h01; alu_raw = AluCmp; end
            OpOri:  begin flags_raw = 8'h81; alu_raw = AluOr;  end
            OpAddi: begin flags_raw = 8'h91; alu_raw = AluAdd; end
            OpLw:   begin flags_raw = 8'h9B; alu_raw = AluAdd; end
            OpLdw:  begin flags_raw = 8'hBB; alu_raw = AluAdd; end
            OpSw:   begin flags_raw = 8'hD4; alu_raw = AluAdd; end
            OpSdw:  begin flags_raw = 8'hF4; alu_raw = AluAdd; end
            OpBz:   begin pc_raw = 6'b000100; alu_raw = AluAdd; end
            OpBgz:  begin pc_raw = 6'b000010; alu_raw = AluAdd; end
            OpBlz:  begin pc_raw = 6'b000001; alu_raw = AluAdd; end
            OpJr:   begin pc_raw = 6'b001000; alu_raw = AluAdd; end
            OpJ:    begin pc_raw = 6'b010000; alu_raw = AluAdd; end
            OpCll:  begin flags_raw = 8'h01; pc_raw = 6'b100000; alu_raw = AluAdd; end
            default: ;
        endcase
    end

    // Stall/kill mask the controls combinationally; the buffer itself is untouched.
    assign bubble   = stall | turn_off | ~valid_q;
    assign cu_flags = bubble ? 8'h00 : flags_raw;
    assign alu_op   = bubble ? AluOr : alu_raw;
    assign {call, jump_f, jr_f, bz, gz, lz} = bubble ? 6'b000000 : pc_raw;

    assign rd_plus1 = rd + 4'd1;

    MUX #(
        .WIDTH  (4),
        .INPUTS (2)
    ) u_rd_mux (
        .inputs ({rd_plus1, rd}),
        .sel    (add_rd),
        .result (rd_value)
    );

    MUX #(
        .WIDTH  (4),
        .INPUTS (2)
    ) u_rb_mux (
        .inputs ({rd_value, rt}),
        .sel    (cu_flags[6]),
        .result (rb)
    );

    MUX #(
        .WIDTH  (4),
        .INPUTS (2)
    ) u_rd_buf_mux (
        .inputs ({LinkReg, rd_value}),
        .sel    (call),
        .result (rd_buf)
    );

endmodule

// File: tb/tb_decode_control_unit.sv
// Directed bench for decode_control_unit: opcode table sweep, bubble masking,
// register selection, reset behaviour and a standalone MUX check.

module tb_decode_control_unit;

    logic        clk = 1'b0;
    logic        clear;
    logic [31:0] instruction;
    logic        stall;
    logic        turn_off;
    logic        add_rd;
    logic [5:0]  op_code;
    logic [3:0]  rd, rs, rt;
    logic [13:0] imm;
    logic [7:0]  cu_flags;
    logic        call, jump_f, jr_f, bz, gz, lz;
    logic [1:0]  alu_op;
    logic [3:0]  rb;
    logic [3:0]  rd_buf;

    logic [127:0] mux_in;
    logic [1:0]   mux_sel;
    logic [31:0]  mux_out;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_control_unit dut (
        .clk         (clk),
        .clear       (clear),
        .instruction (instruction),
        .stall       (stall),
        .turn_off    (turn_off),
        .add_rd      (add_rd),
        .op_code     (op_code),
        .rd          (rd),
        .rs          (rs),
        .rt          (rt),
        .imm         (imm),
        .cu_flags    (cu_flags),
        .call        (call),
        .jump_f      (jump_f),
        .jr_f        (jr_f),
        .bz          (bz),
        .gz          (gz),
        .lz          (lz),
        .alu_op      (alu_op),
        .rb          (rb),
        .rd_buf      (rd_buf)
    );

    MUX #(
        .WIDTH  (32),
        .INPUTS (4)
    ) u_mux4 (
        .inputs (mux_in),
        .sel    (mux_sel),
        .result (mux_out)
    );

    typedef struct {
        logic [5:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rt;
        logic        add_rd;
        logic [7:0]  exp_cu;
        logic [5:0]  exp_pc;   // {call, jump_f, jr_f, bz, gz, lz}
        logic [1:0]  exp_alu;
        logic [3:0]  exp_rb;
        logic [3:0]  exp_rd_buf;
    } vec_t;

    localparam int NumVec = 22;
    vec_t vecs [NumVec];

    function automatic vec_t mk(input logic [5:0] op, input logic [3:0] r_d, input logic [3:0] r_t,
                                input logic ard, input logic [7:0] cu, input logic [5:0] pc,
                                input logic [1:0] alu, input logic [3:0] erb,
                                input logic [3:0] erdb);
        vec_t v;
        v.op = op; v.rd = r_d; v.rt = r_t; v.add_rd = ard;
        v.exp_cu = cu; v.exp_pc = pc; v.exp_alu = alu; v.exp_rb = erb; v.exp_rd_buf = erdb;
        return v;
    endfunction

    function automatic logic [31:0] instr(input logic [5:0] op, input logic [3:0] r_d,
                                          input logic [3:0] r_s, input logic [3:0] r_t,
                                          input logic [13:0] im);
        return {op, r_d, r_s, r_t, im};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [7:0] cu, input logic [5:0] pc,
                              input logic [1:0] alu);
        check({tag, " cu_flags"}, 32'(cu_flags), 32'(cu));
        check({tag, " pc_flags"}, 32'({call, jump_f, jr_f, bz, gz, lz}), 32'(pc));
        check({tag, " alu_op"}, 32'(alu_op), 32'(alu));
    endtask

    initial begin
        // Opcode sweep with rd=3, rt=7: only SW/SDW route rd to rb; CLL forces R14.
        vecs[0]  = mk(6'd0,  4'd3, 4'd7, 1'b0, 8'h01, 6'h00, 2'b00, 4'd7, 4'd3);
        vecs[1]  = mk(6'd1,  4'd3, 4'd7, 1'b0, 8'h01, 6'h00, 2'b01, 4'd7, 4'd3);
        vecs[2]  = mk(6'd2,  4'd3, 4'd7, 1'b0, 8'h01, 6'h00, 2'b10, 4'd7, 4'd3);
        vecs[3]  = mk(6'd3,  4'd3, 4'd7, 1'b0, 8'h01, 6'h00, 2'b11, 4'd7, 4'd3);
        vecs[4]  = mk(6'd4,  4'd3, 4'd7, 1'b0, 8'h81, 6'h00, 2'b00, 4'd7, 4'd3);
        vecs[5]  = mk(6'd5,  4'd3, 4'd7, 1'b0, 8'h91, 6'h00, 2'b01, 4'd7, 4'd3);
        vecs[6]  = mk(6'd6,  4'd3, 4'd7, 1'b0, 8'h9B, 6'h00, 2'b01, 4'd7, 4'd3);
        vecs[7]  = mk(6'd7,  4'd3, 4'd7, 1'b0, 8'hBB, 6'h00, 2'b01, 4'd7, 4'd3);
        vecs[8]  = mk(6'd8,  4'd3, 4'd7, 1'b0, 8'hD4, 6'h00, 2'b01, 4'd3, 4'd3);
        vecs[9]  = mk(6'd9,  4'd3, 4'd7, 1'b0, 8'hF4, 6'h00, 2'b01, 4'd3, 4'd3);
        vecs[10] = mk(6'd10, 4'd3, 4'd7, 1'b0, 8'h00, 6'h04, 2'b01, 4'd7, 4'd3);
        vecs[11] = mk(6'd11, 4'd3, 4'd7, 1'b0, 8'h00, 6'h02, 2'b01, 4'd7, 4'd3);
        vecs[12] = mk(6'd12, 4'd3, 4'd7, 1'b0, 8'h00, 6'h01, 2'b01, 4'd7, 4'd3);
        vecs[13] = mk(6'd13, 4'd3, 4'd7, 1'b0, 8'h00, 6'h08, 2'b01, 4'd7, 4'd3);
        vecs[14] = mk(6'd14, 4'd3, 4'd7, 1'b0, 8'h00, 6'h10, 2'b01, 4'd7, 4'd3);
        vecs[15] = mk(6'd15, 4'd3, 4'd7, 1'b0, 8'h01, 6'h20, 2'b01, 4'd7, 4'hE);
        // Undefined opcodes decode as NOP.
        vecs[16] = mk(6'd20, 4'd3, 4'd7, 1'b0, 8'h00, 6'h00, 2'b00, 4'd7, 4'd3);
        vecs[17] = mk(6'd63, 4'd3, 4'd7, 1'b0, 8'h00, 6'h00, 2'b00, 4'd7, 4'd3);
        // Double-word second halves and the rd wrap.
        vecs[18] = mk(6'd9,  4'd3, 4'd7, 1'b1, 8'hF4, 6'h00, 2'b01, 4'd4, 4'd4);
        vecs[19] = mk(6'd7,  4'd3, 4'd7, 1'b1, 8'hBB, 6'h00, 2'b01, 4'd7, 4'd4);
        vecs[20] = mk(6'd1,  4'd15, 4'd7, 1'b1, 8'h01, 6'h00, 2'b01, 4'd7, 4'd0);
        vecs[21] = mk(6'd8,  4'd15, 4'd2, 1'b1, 8'hD4, 6'h00, 2'b01, 4'd0, 4'd0);

        clear       = 1'b1;
        stall       = 1'b0;
        turn_off    = 1'b0;
        add_rd      = 1'b0;
        instruction = 32'h0440_0000;
        mux_in      = '0;
        mux_sel     = '0;

        // Reset with an ADD pending: a clock edge under clear must not load it.
        @(posedge clk);
        #1;
        check_ctrl("reset", 8'h00, 6'h00, 2'b00);
        check("reset op_code", 32'(op_code), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset op_code", 32'(op_code), 32'd1);
        check("post-reset rd", 32'(rd), 32'd1);
        check_ctrl("post-reset", 8'h01, 6'h00, 2'b01);

        for (int i = 0; i < NumVec; i++) begin
            @(negedge clk);
            instruction = instr(vecs[i].op, vecs[i].rd, 4'd5, vecs[i].rt, 14'h1234);
            add_rd      = vecs[i].add_rd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d op_code", i), 32'(op_code), 32'(vecs[i].op));
            check_ctrl($sformatf("vec%0d", i), vecs[i].exp_cu, vecs[i].exp_pc, vecs[i].exp_alu);
            check($sformatf("vec%0d rb", i), 32'(rb), 32'(vecs[i].exp_rb));
            check($sformatf("vec%0d rd_buf", i), 32'(rd_buf), 32'(vecs[i].exp_rd_buf));
        end
        check("fields rs", 32'(rs), 32'd5);
        check("fields imm", 32'(imm), 32'h1234);

        // Load LW, then sweep all opcodes under stall+turn_off: buffer must hold.
        @(negedge clk);
        add_rd      = 1'b0;
        instruction = instr(6'd6, 4'd3, 4'd0, 4'd7, 14'h0);
        @(posedge clk);
        #1;
        check_ctrl("lw loaded", 8'h9B, 6'h00, 2'b01);
        for (int op = 0; op < 16; op++) begin
            @(negedge clk);
            stall       = 1'b1;
            turn_off    = 1'b1;
            instruction = instr(6'(op), 4'd9, 4'd0, 4'd1, 14'h0);
            @(posedge clk);
            #1;
            check($sformatf("stalled op%0d op_code", op), 32'(op_code), 32'd6);
            check_ctrl($sformatf("stalled op%0d", op), 8'h00, 6'h00, 2'b00);
        end

        // Release: held LW controls reappear combinationally, no clock edge needed.
        stall    = 1'b0;
        turn_off = 1'b0;
        #1;
        check_ctrl("release", 8'h9B, 6'h00, 2'b01);
        // Each mask alone acts within the same cycle.
        stall = 1'b1;
        #1;
        check_ctrl("stall only", 8'h00, 6'h00, 2'b00);
        stall    = 1'b0;
        turn_off = 1'b1;
        #1;
        check_ctrl("turn_off only", 8'h00, 6'h00, 2'b00);
        turn_off = 1'b0;
        #1;
        check_ctrl("unmask", 8'h9B, 6'h00, 2'b01);

        // Asynchronous clear mid-cycle, held across an edge with a CLL pending.
        @(negedge clk);
        instruction = instr(6'd15, 4'd2, 4'd0, 4'd0, 14'h0);
        #2;
        clear = 1'b1;
        #1;
        check_ctrl("async clear", 8'h00, 6'h00, 2'b00);
        check("async clear op_code", 32'(op_code), 32'd0);
        @(posedge clk);
        #1;
        check("clear wins load", 32'(op_code), 32'd0);
        check("clear wins rd_buf", 32'(rd_buf), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk);
        #1;
        check_ctrl("cll after clear", 8'h01, 6'h20, 2'b01);
        check("cll rd_buf", 32'(rd_buf), 32'hE);

        // Standalone 4-input MUX: input 0 is the low slice.
        mux_in = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        for (int s = 0; s < 4; s++) begin
            logic [31:0] exp_m;
            case (s)
                0: exp_m = 32'hDDDD_0004;
                1: exp_m = 32'hCCCC_0003;
                2: exp_m = 32'hBBBB_0002;
                default: exp_m = 32'hAAAA_0001;
            endcase
            mux_sel = 2'(s);
            #1;
            check($sformatf("mux sel%0d", s), mux_out, exp_m);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
